// File: rtl/soc_cpu_router.sv
// soc_cpu_router: 1-to-NUM_TGT router from the CPU native memory port to SOC targets.
// Each request is decoded against a base/mask table, where the lowest matching entry wins.
// A hit is forwarded to that target, which holds the request until tgt_rdy arrives.
// A decode miss gets an ERR_RDATA response and an error pulse.
// Defining SOC_CPU_ROUTER_TIMEOUT_EN adds a per-access watchdog:
//   - after TIMEOUT_CYC ACCESS cycles the access is abandoned
//   - the abandoned access returns an error response.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb   CPU request (wstrb == 0 is a read)
//   cpu_ready/rdata      one-cycle completion pulse and read data
//   tgt_vld              one-hot target request
//   tgt_addr/we/wdat     shared word address, byte strobes, write data
//   tgt_rdy/tgt_rdat     per-target completion and packed read data
//   err_pulse/addr/cnt   error pulse, last error byte address, saturating error count
module soc_cpu_router #(
  parameter int unsigned           NUM_TGT     = 4,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE    = {32'h4000_0000, 32'h2000_0000,
                                                  32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*32-1:0] TGT_MASK    = {32'hC000_0000, 32'hE000_0000,
                                                  32'hF000_0000, 32'hF000_0000},
  parameter int unsigned           TIMEOUT_CYC = 256,
  parameter logic [31:0]           ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_valid,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_wstrb,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic [NUM_TGT-1:0]      tgt_vld,
  output logic [29:0]             tgt_addr,
  output logic [3:0]              tgt_we,
  output logic [31:0]             tgt_wdat,
  input  logic [NUM_TGT-1:0]      tgt_rdy,
  input  logic [NUM_TGT*32-1:0]   tgt_rdat,
  output logic                    err_pulse,
  output logic [31:0]             err_addr,
  output logic [15:0]             err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [NUM_TGT-1:0] tgt_vld_q,   tgt_vld_d;
  logic [29:0]        tgt_addr_q,  tgt_addr_d;
  logic [3:0]         tgt_we_q,    tgt_we_d;
  logic [31:0]        tgt_wdat_q,  tgt_wdat_d;
  logic               err_pulse_q, err_pulse_d;
  logic [31:0]        err_addr_q,  err_addr_d;
  logic [15:0]        err_cnt_q,   err_cnt_d;

`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_q,     tmo_d;
  // byte offset kept so a timeout can report the full byte address
  logic [1:0]  addr_lo_q, addr_lo_d;
`else
  // TIMEOUT_CYC only matters in the timeout build
  localparam int unsigned UNUSED_TMO_CYC = TIMEOUT_CYC;
`endif

  logic [NUM_TGT-1:0] hit_oh_c;
  logic               hit_c;
  logic               sel_rdy_c;
  logic [31:0]        sel_rdat_c;

  // Address decode: lowest matching table entry wins
  always_comb begin
    hit_oh_c = '0;
    hit_c    = 1'b0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (!hit_c && ((cpu_addr & TGT_MASK[i*32 +: 32]) ==
                     (TGT_BASE[i*32 +: 32] & TGT_MASK[i*32 +: 32]))) begin
        hit_oh_c[i] = 1'b1;
        hit_c       = 1'b1;
      end
    end
  end

  // Only the currently selected target's ready/data are observed
  always_comb begin
    sel_rdy_c  = |(tgt_rdy & tgt_vld_q);
    sel_rdat_c = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (tgt_vld_q[i]) sel_rdat_c = sel_rdat_c | tgt_rdat[i*32 +: 32];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    tgt_vld_d   = tgt_vld_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_we_d    = tgt_we_q;
    tgt_wdat_d  = tgt_wdat_q;
    err_pulse_d = 1'b0;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
    tmo_d       = tmo_q;
    addr_lo_d   = addr_lo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          tgt_addr_d = cpu_addr[31:2];
          tgt_we_d   = cpu_wstrb;
          tgt_wdat_d = cpu_wdata;
`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
          addr_lo_d  = cpu_addr[1:0];
          tmo_d      = '0;
`endif
          if (hit_c) begin
            tgt_vld_d = hit_oh_c;
            state_d   = S_ACCESS;
          end else begin
            // miss: no target is strobed, writes are dropped
            cpu_ready_d = 1'b1;
            cpu_rdata_d = ERR_RDATA;
            err_pulse_d = 1'b1;
            err_addr_d  = cpu_addr;
            state_d     = S_RESP;
          end
        end
      end
      S_ACCESS: begin
`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
        tmo_d = tmo_q + 16'd1;
`endif
        if (sel_rdy_c) begin
          cpu_rdata_d = sel_rdat_c;
          cpu_ready_d = 1'b1;
          tgt_vld_d   = '0;
          state_d     = S_RESP;
        end
`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          cpu_rdata_d = ERR_RDATA;
          cpu_ready_d = 1'b1;
          tgt_vld_d   = '0;
          err_pulse_d = 1'b1;
          err_addr_d  = {tgt_addr_q, addr_lo_q};
          state_d     = S_RESP;
        end
`endif
      end
      S_RESP: begin
        // cpu_ready is high this cycle; incoming cpu_valid is ignored
        state_d = S_IDLE;
      end
      default: begin
        tgt_vld_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    // Saturating error counter
    if (err_pulse_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      tgt_vld_q   <= '0;
      tgt_addr_q  <= '0;
      tgt_we_q    <= '0;
      tgt_wdat_q  <= '0;
      err_pulse_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
      tmo_q       <= '0;
      addr_lo_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      tgt_vld_q   <= tgt_vld_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_we_q    <= tgt_we_d;
      tgt_wdat_q  <= tgt_wdat_d;
      err_pulse_q <= err_pulse_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
`ifdef SOC_CPU_ROUTER_TIMEOUT_EN
      tmo_q       <= tmo_d;
      addr_lo_q   <= addr_lo_d;
`endif
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign tgt_vld   = tgt_vld_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_we    = tgt_we_q;
  assign tgt_wdat  = tgt_wdat_q;
  assign err_pulse = err_pulse_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
